scie_fir_mac_seq: RTL

//   Parametrised successor to the single-shot SCIE pipelined unit: a custom-instruction FIR filter.

---
 rtl/scie_fir_mac_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/scie_fir_mac_seq.sv
// SCIE custom-instruction FIR: NTAPS programmable coefficients and a sample delay line, one MAC per cycle.
// Optional SCIE_FIR_SAT_EN: saturate the narrowed result instead of truncating it.
module scie_fir_mac_seq #(
   parameter int DATA_W = 32,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 8,
   parameter int ACC_W  = 48,
   parameter int SHIFT  = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_valid,
   input  logic [31:0]       io_insn,
   input  logic [DATA_W-1:0] io_rs1,
   input  logic [31:0]       io_rs2,
   output logic [DATA_W-1:0] io_rd,
   output logic              io_busy,
   output logic              io_err
);
   // state | meaning
   // IDLE  | accepts LOAD/PUSH/READ/CLEAR
   // MAC   | accumulating tap tap_q into acc
   // DONE  | narrowing acc into result
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_DONE = 2'd2} state_t;

   localparam int IDX_W  = $clog2(NTAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NTAPS - 1);

   localparam logic [6:0] OP_LOAD  = 7'h0B;
   localparam logic [6:0] OP_PUSH  = 7'h2B;
   localparam logic [6:0] OP_READ  = 7'h5B;
   localparam logic [6:0] OP_CLEAR = 7'h7B;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          tap_q, tap_d;
   logic signed [COEF_W-1:0]  coef_q [NTAPS];
   logic signed [COEF_W-1:0]  coef_d [NTAPS];
   logic signed [DATA_W-1:0]  x_q [NTAPS];
   logic signed [DATA_W-1:0]  x_d [NTAPS];
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]         result_q, result_d;
   logic [DATA_W-1:0]         rd_q, rd_d;
   logic                      err_q, err_d;

   logic                      busy, is_load, is_push, is_read, is_clear;
   logic [IDX_W-1:0]          load_idx;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_sh;
   logic [DATA_W-1:0]         narrow;

   assign busy     = (state_q != S_IDLE);
   assign is_load  = io_valid && (io_insn[6:0] == OP_LOAD);
   assign is_push  = io_valid && (io_insn[6:0] == OP_PUSH);
   assign is_read  = io_valid && (io_insn[6:0] == OP_READ);
   assign is_clear = io_valid && (io_insn[6:0] == OP_CLEAR);
   assign load_idx = io_rs2[IDX_W-1:0];

   assign prod     = PROD_W'(x_q[tap_q]) * PROD_W'(coef_q[tap_q]);
   assign prod_ext = ACC_W'(prod);
   assign acc_sh   = acc_q >>> SHIFT;

`ifdef SCIE_FIR_SAT_EN
   logic ovf;
   assign ovf    = !((&acc_sh[ACC_W-1:DATA_W-1]) || !(|acc_sh[ACC_W-1:DATA_W-1]));
   assign narrow = !ovf ? acc_sh[DATA_W-1:0]
                 : (acc_sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});
   logic unused_bits;
   assign unused_bits = ^{io_insn[31:7], io_rs2[31:IDX_W]};
`else
   assign narrow = acc_sh[DATA_W-1:0];
   logic unused_bits;
   assign unused_bits = ^{io_insn[31:7], io_rs2[31:IDX_W], acc_sh[ACC_W-1:DATA_W]};
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         tap_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         rd_q     <= '0;
         err_q    <= 1'b0;
         for (int k = 0; k < NTAPS; k++) begin
            coef_q[k] <= '0;
            x_q[k]    <= '0;
         end
      end else begin
         state_q  <= state_d;
         tap_q    <= tap_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         rd_q     <= rd_d;
         err_q    <= err_d;
         coef_q   <= coef_d;
         x_q      <= x_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      case (state_q)
         S_IDLE: if (is_push) begin
            state_d = S_MAC;
            tap_d   = '0;
         end
         S_MAC: begin
            tap_d = tap_q + 1'b1;
            if (tap_q == LAST_TAP) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      coef_d   = coef_q;
      x_d      = x_q;
      acc_d    = acc_q;
      result_d = result_q;
      rd_d     = rd_q;
      err_d    = err_q;

      // READ never conflicts with the MAC; while busy it just returns the last result.
      if (is_read) rd_d = result_q;

      if (busy) begin
         if (is_load || is_push || is_clear) err_d = 1'b1;
      end else begin
         if (is_load) coef_d[load_idx] = io_rs1[COEF_W-1:0];
         if (is_push) begin
            for (int k = NTAPS - 1; k > 0; k--) x_d[k] = x_q[k-1];
            x_d[0] = io_rs1;
            acc_d  = '0;
         end
         if (is_clear) begin
            for (int k = 0; k < NTAPS; k++) x_d[k] = '0;
            acc_d    = '0;
            result_d = '0;
            err_d    = 1'b0;
         end
      end

      if (state_q == S_MAC)  acc_d    = acc_q + prod_ext;
      if (state_q == S_DONE) result_d = narrow;
   end

   assign io_busy = busy;
   assign io_rd   = rd_q;
   assign io_err  = err_q;
endmodule
